// File: rtl/cnt_pkg.sv
// Shared constants for the chainable modulo counters: default moduli, clock rate and
// direction encoding.
package cnt_pkg;

  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HOUR_MOD = 24;
  localparam int unsigned CLK_HZ   = 50_000_000;

  // Divider ratio giving one tick per second at CLK_HZ.
  localparam int unsigned DIV_1HZ = CLK_HZ;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/tick_gen.sv
// Runtime-programmable divider: emits a registered one-cycle tick every div_num enabled
// clk cycles (every cycle for div_num of 0 or 1).
module tick_gen import cnt_pkg::*; #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_num,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (div_num < DIV_W'(2)) begin
      cnt_d  = '0;
      tick_d = en;
    end else if (en) begin
      // >= rather than == so a ratio lowered below the current count wraps at once.
      if (cnt_q >= div_num - DIV_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/cnt_mod_nco.sv
// Chainable modulo-MOD up/down counter stepped by an internal programmable tick, with
// clear, saturating load and a one-cycle carry/borrow pulse.
module cnt_mod_nco import cnt_pkg::*; #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MOD   = SEC_MOD,
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_num,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             carry
);

  if (MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("cnt_mod_nco: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .div_num(div_num),
    .tick   (tick)
  );

  always_comb begin
    out_d   = out_q;
    carry_d = 1'b0;
    if (clr) begin
      out_d = '0;
    end else if (load) begin
      out_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (tick && en) begin
      if (up_dn == DIR_UP) begin
        if (out_q >= MaxVal) begin
          out_d   = '0;
          carry_d = 1'b1;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          out_d   = MaxVal;
          carry_d = 1'b1;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_cnt_mod_nco.sv
// Directed bench for cnt_mod_nco (WIDTH=6, MOD=60) with hand-computed expectations.
module tb_cnt_mod_nco;

  logic        clk;
  logic        rst_n;
  logic [31:0] div_num;
  logic        en;
  logic        up_dn;
  logic        clr;
  logic        load;
  logic [5:0]  load_val;
  logic [5:0]  out;
  logic        tick;
  logic        carry;

  int n_pass  = 0;
  int n_total = 0;
  int carries = 0;

  cnt_mod_nco #(
    .WIDTH(6),
    .MOD  (60),
    .DIV_W(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .div_num (div_num),
    .en      (en),
    .up_dn   (up_dn),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .tick    (tick),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    div_num  = 32'd5;
    en       = 1'b1;
    up_dn    = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 6'd0;
    #12;
    check("rst_out", 32'(out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_carry", 32'(carry), 0);
    rst_n = 1'b1;

    // Divide by 5: tick after edges 5,10,...; out=k after edge 5k+1.
    for (int e = 1; e <= 61; e++) begin
      cyc();
      if (e == 4)  check("div5_tick_e4", 32'(tick), 0);
      if (e == 5)  check("div5_tick_e5", 32'(tick), 1);
      if (e == 5)  check("div5_out_e5", 32'(out), 0);
      if (e == 6)  check("div5_out_e6", 32'(out), 1);
      if (e == 6)  check("div5_tick_e6", 32'(tick), 0);
      if (e == 60) check("div5_out_e60", 32'(out), 11);
      if (e == 61) check("div5_out_e61", 32'(out), 12);
    end

    // Wrap up at full rate: clear to 0, then one step per edge.
    clr     = 1'b1;
    div_num = 32'd0;
    cyc();
    check("clr_out", 32'(out), 0);
    clr = 1'b0;
    carries = 0;
    for (int k = 1; k <= 61; k++) begin
      cyc();
      if (carry) carries++;
      if (k == 59) check("up_out59", 32'(out), 59);
      if (k == 59) check("up_carry59", 32'(carry), 0);
      if (k == 60) check("up_wrap_out", 32'(out), 0);
      if (k == 60) check("up_wrap_carry", 32'(carry), 1);
      if (k == 61) check("up_after_carry", 32'(carry), 0);
      if (k == 61) check("up_after_out", 32'(out), 1);
    end
    check("up_carry_count", 32'(carries), 1);

    // Wrap down from 0.
    load     = 1'b1;
    load_val = 6'd0;
    cyc();
    check("load0_out", 32'(out), 0);
    load  = 1'b0;
    up_dn = 1'b0;
    cyc();
    check("dn_wrap_out", 32'(out), 59);
    check("dn_wrap_carry", 32'(carry), 1);
    cyc();
    check("dn_out58", 32'(out), 58);
    check("dn_carry58", 32'(carry), 0);
    cyc();
    check("dn_out57", 32'(out), 57);

    // Priority and saturation with a tick present every edge.
    clr      = 1'b1;
    load     = 1'b1;
    load_val = 6'd20;
    cyc();
    check("clr_over_load_out", 32'(out), 0);
    check("clr_over_load_carry", 32'(carry), 0);
    clr      = 1'b0;
    load_val = 6'd63;
    cyc();
    check("load_sat_out", 32'(out), 59);
    check("load_sat_carry", 32'(carry), 0);
    up_dn    = 1'b1;
    load_val = 6'd10;
    cyc();
    check("load_over_tick", 32'(out), 10);
    load = 1'b0;
    cyc();
    check("step_after_load", 32'(out), 11);

    // Runtime divider change: ratio 100, cut to 10 once cnt reaches 49.
    div_num = 32'd100;
    for (int a = 1; a <= 49; a++) cyc();
    check("div100_out", 32'(out), 12);
    check("div100_tick", 32'(tick), 0);
    div_num = 32'd10;
    cyc();
    check("div_cut_tick", 32'(tick), 1);
    check("div_cut_out", 32'(out), 12);
    for (int b = 2; b <= 11; b++) begin
      cyc();
      if (b == 2)  check("div10_out_b2", 32'(out), 13);
      if (b == 10) check("div10_tick_b10", 32'(tick), 0);
      if (b == 11) check("div10_tick_b11", 32'(tick), 1);
    end
    cyc();
    check("pre_hold_out", 32'(out), 14);
    en = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (tick) check("hold_tick", 32'(tick), 0);
    end
    check("hold_out", 32'(out), 14);
    check("hold_tick_end", 32'(tick), 0);
    en = 1'b1;
    for (int d = 1; d <= 10; d++) begin
      cyc();
      if (d == 8)  check("resume_tick_d8", 32'(tick), 0);
      if (d == 9)  check("resume_tick_d9", 32'(tick), 1);
      if (d == 9)  check("resume_out_d9", 32'(out), 14);
      if (d == 10) check("resume_out_d10", 32'(out), 15);
    end

    // Async reset between edges while out=37.
    load     = 1'b1;
    load_val = 6'd37;
    cyc();
    load = 1'b0;
    check("pre_rst_out", 32'(out), 37);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 0);
    check("async_rst_tick", 32'(tick), 0);
    check("async_rst_carry", 32'(carry), 0);
    #2;
    rst_n = 1'b1;
    for (int r = 1; r <= 11; r++) begin
      cyc();
      if (r == 9)  check("post_rst_tick_r9", 32'(tick), 0);
      if (r == 10) check("post_rst_tick_r10", 32'(tick), 1);
      if (r == 10) check("post_rst_out_r10", 32'(out), 0);
      if (r == 11) check("post_rst_out_r11", 32'(out), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
